fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of write requesters (2..8).
REQ-002 Parameter DATA_W, default FIFO_WIDTH, SHALL set the word width.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req  in  N_REQ  per-requester write request.
REQ-006 req_data  in  N_REQ x DATA_W  per-requester write word.
REQ-007 gnt  out  N_REQ  one-hot acceptance pulse.
REQ-008 fifo_wr_en  out  1  write enable to FIFO.
REQ-009 fifo_data_in  out  DATA_W  write word to FIFO.
REQ-010 fifo_full  in  1  FIFO full flag.
REQ-011 fifo_wr_ack  in  1  FIFO registered write acknowledge.
REQ-012 busy  out  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, RESP, STALL.
REQ-014 IDLE: if any req and !fifo_full, pick winner round-robin starting at pointer ptr, latch winner index and req_data[winner], go to ISSUE; otherwise stay in IDLE.
REQ-015 ISSUE: fifo_wr_en=1 and fifo_data_in=latched word for exactly this cycle; go to RESP.
REQ-016 RESP: fifo_wr_ack=1 -> gnt[winner]=1 (combinational, this cycle only), ptr=(winner+1) mod N_REQ, go to IDLE.
REQ-017 RESP: fifo_wr_ack=0 (overflow) -> no gnt, ptr unchanged, go to STALL.
REQ-018 STALL: wait while fifo_full=1; when fifo_full=0 go to ISSUE and retry the same latched word.
REQ-019 Latency: word accepted at arbitration edge -> fifo_wr_en high next cycle -> gnt the cycle after; sustained throughput one word per 3 cycles.
REQ-020 Handshake: requester SHALL hold req and req_data until gnt; req dropped after arbitration SHALL NOT cancel the in-flight word.
REQ-021 fifo_wr_en SHALL be 0 in IDLE, RESP, STALL; gnt SHALL be 0 outside RESP.
REQ-022 Pointer wrap: ptr at N_REQ-1 SHALL advance to 0.
REQ-023 Single requester SHALL be re-granted every 3 cycles while req held; no starvation with all req high (each requester granted once per N_REQ grants).

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, ptr=0, gnt=0, fifo_wr_en=0, fifo_data_in=0, busy=0.
REQ-025 Reset mid-operation SHALL drop the in-flight word with no gnt.

Configuration
REQ-026 With ARB_STATS_EN defined: outputs acc_cnt (N_REQ x 16, per-requester granted words) and retry_cnt (16, RESP->STALL transitions), saturating at 16'hFFFF, reset to 0.
REQ-027 Without ARB_STATS_EN: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-028 shared_pkg SHALL hold N_REQ default and typedef enum arb_state_e {IDLE, ISSUE, RESP, STALL}; FIFO_WIDTH stays there.
REQ-029 Round-robin selection SHALL live in combinational sub-module rr_pick (inputs req, ptr; outputs valid, winner index).

Verification
REQ-030 Reset: rst_n=0 during ISSUE -> fifo_wr_en=0 immediately, no gnt, ptr=0 after release.
REQ-031 req=4'b0001, data 16'hA5A5, FIFO empty -> fifo_wr_en in cycle 1 with 16'hA5A5, gnt=4'b0001 in cycle 2.
REQ-032 req=4'b1111 held, FIFO never full -> grant order 0,1,2,3,0 and 5 FIFO writes.
REQ-033 FIFO full before arbitration, req=4'b0010 -> no fifo_wr_en until fifo_full=0, then normal grant.
REQ-034 fifo_wr_ack=0 in RESP -> STALL, retry same word after fifo_full falls, gnt only on ack; retry_cnt=1 with ARB_STATS_EN.
REQ-035 Scoreboard: FIFO contents equal the ordered list of granted words across 3000 random req/full cycles.

Source files
------------

// File: rtl/shared_pkg.sv
// shared_pkg: common widths, requester-count default and arbiter FSM states
package shared_pkg;
  localparam int FIFO_WIDTH = 16;
  localparam int N_REQ_DEF = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP, STALL} arb_state_e;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search starting at ptr
//   req    in  N_REQ  request vector
//   ptr    in  IW     highest-priority index this round
//   valid  out 1      any request present
//   winner out IW     first requesting index at or after ptr (wrapping)
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    winner
);
  assign valid = |req;
  // Scan offsets from farthest to nearest so the closest requester to ptr wins.
  always_comb begin
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N_REQ]) winner = IW'((int'(ptr) + i) % N_REQ);
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter feeding N_REQ write requesters into one FIFO
//   clk, rst_n          clock, asynchronous active-low reset
//   req, req_data       per-requester request and flat N_REQ x DATA_W words
//   gnt                 one-hot acceptance pulse, in RESP on write ack
//   fifo_wr_en, fifo_data_in, fifo_full, fifo_wr_ack  FIFO write port
//   busy                FSM not in IDLE
//   ARB_STATS_EN adds acc_cnt (N_REQ x 16 grants) and retry_cnt (16, overflow retries)
module fifo_wr_arbiter
  import shared_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DATA_W = FIFO_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    fifo_wr_en,
  output logic [DATA_W-1:0]       fifo_data_in,
  input  logic                    fifo_full,
  input  logic                    fifo_wr_ack,
  output logic                    busy
`ifdef ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]     acc_cnt,
  output logic [15:0]             retry_cnt
`endif
);
  localparam int IW = $clog2(N_REQ);
  arb_state_e state, state_nx;
  logic [IW-1:0] ptr, win, pick;
  logic pick_v, arb, acked;
  logic [DATA_W-1:0] word;
  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req(req),
    .ptr(ptr),
    .valid(pick_v),
    .winner(pick)
  );
  assign arb = state == IDLE && pick_v && !fifo_full;
  assign acked = state == RESP && fifo_wr_ack;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = arb ? ISSUE : IDLE;
      ISSUE:   state_nx = RESP;
      RESP:    state_nx = fifo_wr_ack ? IDLE : STALL;
      default: state_nx = fifo_full ? STALL : ISSUE;
    endcase
  end
  // Winner and word are latched at arbitration so a dropped req cannot cancel the write.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      win <= '0;
      word <= '0;
    end else begin
      if (arb) begin
        win <= pick;
        word <= req_data[pick*DATA_W +: DATA_W];
      end
      if (acked) ptr <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
    end
  always_comb begin
    busy = state != IDLE;
    fifo_wr_en = state == ISSUE;
    fifo_data_in = fifo_wr_en ? word : '0;
    gnt = acked ? N_REQ'(1) << win : '0;
  end
`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_cnt <= '0;
      retry_cnt <= '0;
    end else begin
      if (acked && acc_cnt[win*16 +: 16] != 16'hFFFF) acc_cnt[win*16 +: 16] <= acc_cnt[win*16 +: 16] + 16'd1;
      if (state == RESP && !fifo_wr_ack && retry_cnt != 16'hFFFF) retry_cnt <= retry_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [3:0] req = 0, gnt;
  logic [63:0] req_data = 0;
  logic fifo_wr_en, fifo_full = 0, fifo_wr_ack, busy, drop = 0;
  logic [15:0] fifo_data_in;
`ifdef ARB_STATS_EN
  logic [63:0] acc_cnt;
  logic [15:0] retry_cnt;
`endif
  int cmps = 0, fails = 0, wr_cnt = 0, n, b0;
  logic [15:0] fifo_q[$], exp_q[$];
  fifo_wr_arbiter dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .fifo_wr_en(fifo_wr_en),
    .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full),
    .fifo_wr_ack(fifo_wr_ack),
    .busy(busy)
`ifdef ARB_STATS_EN
    ,
    .acc_cnt(acc_cnt),
    .retry_cnt(retry_cnt)
`endif
  );
  // FIFO model: accepts a write when not full and not forced to overflow, acks one cycle later.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) fifo_wr_ack <= 0;
    else begin
      fifo_wr_ack <= fifo_wr_en && !fifo_full && !drop;
      if (fifo_wr_en) wr_cnt <= wr_cnt + 1;
      if (fifo_wr_en && !fifo_full && !drop) fifo_q.push_back(fifo_data_in);
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_gnt(input logic [3:0] exp, input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (gnt === 4'b0 && cyc < 12);
    chk(tag, gnt, exp);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_data", fifo_data_in, 0);
    rst_n = 1;
    req = 4'b0001;
    req_data[15:0] = 16'hA5A5;
    @(negedge clk);
    chk("a_wr_en", fifo_wr_en, 1);
    chk("a_data", fifo_data_in, 16'hA5A5);
    chk("a_gnt_early", gnt, 0);
    @(negedge clk);
    chk("a_gnt", gnt, 4'b0001);
    chk("a_wr_en_resp", fifo_wr_en, 0);
    req = 0;
    @(negedge clk);
    chk("a_idle", busy, 0);
    fifo_full = 1;
    req = 4'b0010;
    req_data[31:16] = 16'hBEEF;
    repeat (3) begin
      @(negedge clk);
      chk("c_no_wr", fifo_wr_en, 0);
      chk("c_idle", busy, 0);
    end
    fifo_full = 0;
    @(negedge clk);
    chk("c_wr_en", fifo_wr_en, 1);
    chk("c_data", fifo_data_in, 16'hBEEF);
    @(negedge clk);
    chk("c_gnt", gnt, 4'b0010);
    req = 0;
    @(negedge clk);
    req = 4'b0100;
    req_data[47:32] = 16'h1234;
    @(negedge clk);
    chk("r_wr_en", fifo_wr_en, 1);
    req = 0;
    rst_n = 0;
    #1;
    chk("r_wr_en_rst", fifo_wr_en, 0);
    chk("r_busy", busy, 0);
    chk("r_data", fifo_data_in, 0);
    @(negedge clk);
    chk("r_gnt", gnt, 0);
    rst_n = 1;
    for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = 16'h1000 + 16'(i);
    req = 4'b1111;
    b0 = wr_cnt;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(4'b0001 << (k % 4), "b_gnt", n);
      chk("b_gap", n, k == 0 ? 2 : 3);
    end
    req = 0;
    @(negedge clk);
    chk("b_writes", wr_cnt - b0, 5);
    req = 4'b1000;
    req_data[63:48] = 16'hCAFE;
    @(negedge clk);
    chk("d_wr_en", fifo_wr_en, 1);
    drop = 1;
    fifo_full = 1;
    @(negedge clk);
    chk("d_no_gnt", gnt, 0);
    drop = 0;
    repeat (2) begin
      @(negedge clk);
      chk("d_stall_wr", fifo_wr_en, 0);
      chk("d_stall_busy", busy, 1);
      chk("d_stall_gnt", gnt, 0);
    end
    fifo_full = 0;
    @(negedge clk);
    chk("d_retry_wr", fifo_wr_en, 1);
    chk("d_retry_data", fifo_data_in, 16'hCAFE);
    @(negedge clk);
    chk("d_gnt", gnt, 4'b1000);
    req = 0;
    @(negedge clk);
`ifdef ARB_STATS_EN
    chk("d_retry_cnt", retry_cnt, 1);
    chk("d_acc3", acc_cnt[63:48], 2);
    chk("d_acc0", acc_cnt[15:0], 2);
`endif
    fifo_q.delete();
    exp_q.delete();
    for (int c = 0; c < 3100; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) begin
          exp_q.push_back(req_data[i*16 +: 16]);
          req[i] = 0;
        end
        if (c < 3000 && !req[i] && $urandom_range(0, 2) == 0) begin
          req_data[i*16 +: 16] = 16'($urandom);
          req[i] = 1;
        end
      end
      fifo_full = (c < 3000) && ($urandom_range(0, 3) == 0);
    end
    chk("drain_req", req, 0);
    chk("drain_busy", busy, 0);
    chk("sb_nonempty", exp_q.size() > 100, 1);
    chk("sb_len", fifo_q.size(), exp_q.size());
    for (int i = 0; i < fifo_q.size() && i < exp_q.size(); i++) chk("sb_word", fifo_q[i], exp_q[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end
endmodule
